// File: rtl/vote_pkg.sv
// Shared definitions for the vote result unit: FSM state encoding and default sizing.
package vote_pkg;

    localparam int DEF_NUM_CAND = 4;
    localparam int DEF_CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } vote_state_e;

    // Candidate index width; a single candidate still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vote_result_unit_if.sv
// Request/display bundle between the vote controller side and the result unit.
interface vote_result_unit_if #(
    parameter int NUM_CAND = vote_pkg::DEF_NUM_CAND,
    parameter int CNT_W    = vote_pkg::DEF_CNT_W
);
    logic                      mode;
    logic                      button;
    logic [NUM_CAND-1:0]       candidate;
    logic [NUM_CAND*CNT_W-1:0] vote_counts;
    logic [CNT_W-1:0]          led;
    logic [NUM_CAND-1:0]       winner;
    logic                      tie;
    logic                      busy;
    logic                      done;

    modport master (
        output mode, button, candidate, vote_counts,
        input  led, winner, tie, busy, done
    );

    modport slave (
        input  mode, button, candidate, vote_counts,
        output led, winner, tie, busy, done
    );
endinterface

// File: rtl/vote_result_unit_btn_edge.sv
// Rising-edge detector for a debounced push-button level.
module btn_edge (
    input  logic clk,
    input  logic reset_all,
    input  logic in,
    output logic rise
);
    logic hist_q;
    logic armed_q;

    // armed_q stays low until the button is seen released after reset, so a
    // button held through reset release never counts as a press.
    always_ff @(posedge clk) begin
        if (reset_all) begin
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= in;
            armed_q <= armed_q | ~in;
        end
    end

    assign rise = in & ~hist_q & armed_q;
endmodule

// File: rtl/vote_result_unit.sv
// Result-phase display unit: manual count select and sequential winner scan.
//   state   | meaning
//   IDLE    | waiting for a button press (or held in voting phase)
//   SCAN    | one candidate compared per cycle against the running max
//   DONE    | one-cycle result strobe, then back to IDLE
module vote_result_unit
    import vote_pkg::*;
#(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_all,
    vote_result_unit_if.slave bus
);
    localparam int               IDX_W    = idx_width(NUM_CAND);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    vote_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    best_q, best_d;
    logic [CNT_W-1:0]    max_q, max_d;
    logic                scan_tie_q, scan_tie_d;
    logic [CNT_W-1:0]    led_q, led_d;
    logic [NUM_CAND-1:0] winner_q, winner_d;
    logic                tie_q, tie_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                rise;
    logic                sel_onehot;
    logic [CNT_W-1:0]    sel_count;
    logic [CNT_W-1:0]    scan_count;
    logic [CNT_W-1:0]    max_n;
    logic [IDX_W-1:0]    best_n;
    logic                tie_n;

    btn_edge u_btn_edge (
        .clk       (clk),
        .reset_all (reset_all),
        .in        (bus.button),
        .rise      (rise)
    );

    assign sel_onehot = (bus.candidate != '0) &&
                        ((bus.candidate & (bus.candidate - NUM_CAND'(1))) == '0);

    always_comb begin
        sel_count  = '0;
        scan_count = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (bus.candidate[i])
                sel_count |= bus.vote_counts[i*CNT_W +: CNT_W];
            if (idx_q == IDX_W'(i))
                scan_count = bus.vote_counts[i*CNT_W +: CNT_W];
        end
    end

    // An equal count at index 0 only seeds max; later equals mark a shared maximum.
    always_comb begin
        max_n  = max_q;
        best_n = best_q;
        tie_n  = scan_tie_q;
        if (scan_count > max_q) begin
            max_n  = scan_count;
            best_n = idx_q;
            tie_n  = 1'b0;
        end else if ((scan_count == max_q) && (idx_q != '0)) begin
            tie_n = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_d     = best_q;
        max_d      = max_q;
        scan_tie_d = scan_tie_q;
        led_d      = led_q;
        winner_d   = winner_q;
        tie_d      = tie_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        if (!bus.mode) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            best_d     = '0;
            max_d      = '0;
            scan_tie_d = 1'b0;
            led_d      = '0;
            winner_d   = '0;
            tie_d      = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        if (bus.candidate == '0) begin
                            state_d    = ST_SCAN;
                            busy_d     = 1'b1;
                            idx_d      = '0;
                            best_d     = '0;
                            max_d      = '0;
                            scan_tie_d = 1'b0;
                        end else if (sel_onehot) begin
                            led_d = sel_count;
                        end else begin
                            led_d = '0;
                        end
                    end
                end
                ST_SCAN: begin
                    max_d      = max_n;
                    best_d     = best_n;
                    scan_tie_d = tie_n;
                    idx_d      = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        // Results land together with the DONE strobe.
                        state_d  = ST_DONE;
                        idx_d    = '0;
                        done_d   = 1'b1;
                        led_d    = max_n;
                        tie_d    = tie_n;
                        winner_d = tie_n ? '0 : (NUM_CAND'(1) << best_n);
                    end else begin
                        busy_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset_all) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            best_q     <= '0;
            max_q      <= '0;
            scan_tie_q <= 1'b0;
            led_q      <= '0;
            winner_q   <= '0;
            tie_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            max_q      <= max_d;
            scan_tie_q <= scan_tie_d;
            led_q      <= led_d;
            winner_q   <= winner_d;
            tie_q      <= tie_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.led    = led_q;
    assign bus.winner = winner_q;
    assign bus.tie    = tie_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_vote_result_unit.sv
// Randomized and directed bench for vote_result_unit against a behavioural model.
module tb_vote_result_unit;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset_all;
    always #5 clk = ~clk;

    vote_result_unit_if #(.NUM_CAND(N),  .CNT_W(W))  bus ();
    vote_result_unit_if #(.NUM_CAND(2),  .CNT_W(12)) sw2 ();
    vote_result_unit_if #(.NUM_CAND(16), .CNT_W(12)) sw16 ();

    vote_result_unit #(.NUM_CAND(N), .CNT_W(W)) dut (
        .clk(clk), .reset_all(reset_all), .bus(bus));
    vote_result_unit #(.NUM_CAND(2), .CNT_W(12)) u_sw2 (
        .clk(clk), .reset_all(reset_all), .bus(sw2));
    vote_result_unit #(.NUM_CAND(16), .CNT_W(12)) u_sw16 (
        .clk(clk), .reset_all(reset_all), .bus(sw16));

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_led, res_led;
    logic [N-1:0] m_winner, res_winner;
    logic m_tie, m_busy, m_done, res_tie;
    bit   m_prev, m_seen_low, m_in_done, m_rise;
    int   m_left;
    int   mv, mbest, mpos, mnum;

    function automatic int cnt_of(input int i);
        return int'(bus.vote_counts[i*W +: W]);
    endfunction

    initial begin
        m_led = '0; m_winner = '0; m_tie = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_prev = 1'b0; m_seen_low = 1'b0; m_in_done = 1'b0; m_left = 0;
    end

    always @(posedge clk) begin
        m_rise = bus.button && !m_prev && m_seen_low;
        if (reset_all) begin
            m_led = '0; m_winner = '0; m_tie = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_prev = 1'b0; m_seen_low = 1'b0; m_in_done = 1'b0; m_left = 0;
        end else begin
            m_prev = bus.button;
            if (!bus.button) m_seen_low = 1'b1;
            m_done = 1'b0;
            if (!bus.mode) begin
                m_led = '0; m_winner = '0; m_tie = 1'b0; m_busy = 1'b0;
                m_left = 0; m_in_done = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_in_done = 1'b1;
                    m_led = res_led; m_tie = res_tie; m_winner = res_winner;
                end
            end else if (m_in_done) begin
                m_in_done = 1'b0;
            end else if (m_rise) begin
                if (bus.candidate == '0) begin
                    m_left = N;
                    m_busy = 1'b1;
                    mbest = -1; mpos = 0; mnum = 0;
                    for (int i = 0; i < N; i++) begin
                        mv = cnt_of(i);
                        if (mv > mbest) begin mbest = mv; mpos = i; end
                    end
                    for (int i = 0; i < N; i++) if (cnt_of(i) == mbest) mnum++;
                    res_led    = W'(mbest);
                    res_tie    = (mnum > 1);
                    res_winner = res_tie ? '0 : N'(1 << mpos);
                end else if ($countones(bus.candidate) == 1) begin
                    for (int i = 0; i < N; i++) if (bus.candidate[i]) m_led = W'(cnt_of(i));
                end else begin
                    m_led = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_led",    32'(bus.led),    32'(m_led));
            check("cyc_winner", 32'(bus.winner), 32'(m_winner));
            check("cyc_tie",    32'(bus.tie),    32'(m_tie));
            check("cyc_busy",   32'(bus.busy),   32'(m_busy));
            check("cyc_done",   32'(bus.done),   32'(m_done));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
        bus.vote_counts = {W'(c3), W'(c2), W'(c1), W'(c0)};
    endtask

    task automatic scan_expect(input string nm, input int el, input logic [N-1:0] ew, input logic et);
        bus.candidate = '0;
        bus.button = 1'b0;
        tick(1);
        bus.button = 1'b1;
        tick(1);
        for (int k = 0; k < N; k++) begin
            check({nm, "_busy"},   32'(bus.busy), 32'd1);
            check({nm, "_nodone"}, 32'(bus.done), 32'd0);
            tick(1);
        end
        check({nm, "_done"},      32'(bus.done),   32'd1);
        check({nm, "_busy_lo"},   32'(bus.busy),   32'd0);
        check({nm, "_led"},       32'(bus.led),    32'(el));
        check({nm, "_winner"},    32'(bus.winner), 32'(ew));
        check({nm, "_tie"},       32'(bus.tie),    32'(et));
        check({nm, "_model_led"}, 32'(m_led),      32'(el));
        tick(1);
        check({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({nm, "_led_hold"},   32'(bus.led),  32'(el));
        bus.button = 1'b0;
    endtask

    task automatic reload_counts(input int c0, input int c1, input int c2, input int c3);
        bus.mode = 1'b0;
        set_counts(c0, c1, c2, c3);
        tick(1);
        bus.mode = 1'b1;
        tick(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int l2, l16, edges, sel;
    bit seen2, seen16;

    initial begin
        reset_all = 1'b1;
        bus.mode = 1'b0; bus.button = 1'b1; bus.candidate = 4'b0001;
        set_counts(5, 9, 3, 7);
        sw2.mode = 1'b0;  sw2.button = 1'b0;  sw2.candidate = '0;  sw2.vote_counts = '0;
        sw16.mode = 1'b0; sw16.button = 1'b0; sw16.candidate = '0; sw16.vote_counts = '0;
        tick(3);
        chk_en = 1'b1;
        check("rst_led",    32'(bus.led),    32'd0);
        check("rst_winner", 32'(bus.winner), 32'd0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);

        // button held high through reset release must not trigger a load
        bus.mode = 1'b1;
        tick(1);
        reset_all = 1'b0;
        tick(4);
        check("no_req_after_reset", 32'(bus.led), 32'd0);

        // manual select, then holding the button gives no further loads
        bus.button = 1'b0; bus.candidate = 4'b0010;
        tick(1);
        bus.button = 1'b1;
        tick(1);
        check("manual_led", 32'(bus.led), 32'd9);
        check("model_manual_led", 32'(m_led), 32'd9);
        bus.candidate = 4'b0100;
        tick(9);
        check("manual_hold", 32'(bus.led), 32'd9);
        bus.button = 1'b0;
        tick(1);

        scan_expect("scan", 9, 4'b0010, 1'b0);

        reload_counts(8, 2, 8, 1);
        check("mode0_led", 32'(bus.led), 32'd0);
        scan_expect("tie", 8, 4'b0000, 1'b1);
        reload_counts(0, 0, 0, 0);
        scan_expect("zero", 0, 4'b0000, 1'b1);

        // illegal multi-hot select keeps winner/tie from the prior scan
        reload_counts(5, 9, 3, 7);
        scan_expect("scan2", 9, 4'b0010, 1'b0);
        bus.candidate = 4'b0001; tick(1); bus.button = 1'b1; tick(1);
        check("sel0_led", 32'(bus.led), 32'd5);
        bus.button = 1'b0; bus.candidate = 4'b0110; tick(1); bus.button = 1'b1; tick(1);
        check("multihot_led",    32'(bus.led),    32'd0);
        check("multihot_winner", 32'(bus.winner), 32'b0010);
        bus.button = 1'b0;

        // button rise during a scan is ignored and not queued
        bus.candidate = '0; tick(1);
        bus.button = 1'b1; tick(1);
        bus.button = 1'b0; tick(1);
        bus.button = 1'b1; bus.candidate = 4'b0001; tick(1);
        tick(2);
        check("ign_done", 32'(bus.done), 32'd1);
        check("ign_led",  32'(bus.led),  32'd9);
        tick(4);
        check("ign_no_queue_busy", 32'(bus.busy), 32'd0);
        check("ign_no_queue_led",  32'(bus.led),  32'd9);
        bus.button = 1'b0; tick(1);

        // abort by mode drop on 2nd scan cycle
        bus.candidate = '0; bus.button = 1'b1; tick(2);
        bus.mode = 1'b0; tick(1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_led",  32'(bus.led),  32'd0);
        bus.mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("abort_no_done", 32'(bus.done), 32'd0);
            tick(1);
        end
        bus.button = 1'b0; tick(1);

        // reset on 3rd scan cycle
        bus.candidate = 4'b0010; bus.button = 1'b1; tick(1);
        bus.button = 1'b0; bus.candidate = '0; tick(1);
        bus.button = 1'b1; tick(3);
        reset_all = 1'b1; tick(1);
        check("midrst_led",  32'(bus.led),  32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        reset_all = 1'b0; tick(3);
        check("midrst_no_req", 32'(bus.busy), 32'd0);
        bus.button = 1'b0; bus.mode = 1'b0; tick(1);

        // randomized traffic; counts only change while in voting phase
        for (int it = 0; it < 600; it++) begin
            reset_all = ($urandom_range(0, 99) < 2);
            if (!bus.mode && $urandom_range(0, 1) == 0)
                for (int i = 0; i < N; i++)
                    bus.vote_counts[i*W +: W] = ($urandom_range(0, 7) == 0) ? W'(255) : W'($urandom_range(0, 6));
            if ($urandom_range(0, 99) < 4) bus.mode = ~bus.mode;
            if ($urandom_range(0, 99) < 35) bus.button = ~bus.button;
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      bus.candidate = '0;
            else if (sel < 8) bus.candidate = N'(1 << $urandom_range(0, N-1));
            else              bus.candidate = N'($urandom);
            tick(1);
        end
        reset_all = 1'b0; bus.mode = 1'b0; bus.button = 1'b0;
        tick(2);

        // parameter sweep: max count at the last index
        sw2.vote_counts = {12'd4095, 12'($urandom_range(0, 4094))};
        for (int i = 0; i < 15; i++) sw16.vote_counts[i*12 +: 12] = 12'($urandom_range(0, 4094));
        sw16.vote_counts[180 +: 12] = 12'd4095;
        sw2.mode = 1'b1; sw16.mode = 1'b1;
        tick(1);
        sw2.button = 1'b1; sw16.button = 1'b1;
        tick(1);
        edges = 1; l2 = 0; l16 = 0; seen2 = 1'b0; seen16 = 1'b0;
        for (int k = 0; k < 40 && !(seen2 && seen16); k++) begin
            tick(1);
            edges++;
            if (!seen2 && sw2.done) begin
                seen2 = 1'b1; l2 = edges;
                check("sw2_winner", 32'(sw2.winner), 32'h2);
                check("sw2_led",    32'(sw2.led),    32'd4095);
                check("sw2_tie",    32'(sw2.tie),    32'd0);
            end
            if (!seen16 && sw16.done) begin
                seen16 = 1'b1; l16 = edges;
                check("sw16_winner", 32'(sw16.winner), 32'h8000);
                check("sw16_led",    32'(sw16.led),    32'd4095);
                check("sw16_tie",    32'(sw16.tie),    32'd0);
            end
        end
        check("sw2_latency",  32'(l2),  32'd3);
        check("sw16_latency", 32'(l16), 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
